// File: rtl/object_spawn_dispatcher_pkg.sv
// object_spawn_dispatcher_pkg: shared field widths, object codes, FSM states and helpers for the spawn dispatcher
package object_spawn_dispatcher_pkg;
  localparam int DIR_W = 3;
  localparam int POS_W = 10;
  localparam int SPEED_W = 5;
  localparam int TIME_W = 8;
  localparam int TRIG_W = 2;
  localparam int SIZE_W = 10;
  localparam int SCALE_FACTOR_BITS = 3;
  typedef enum logic [DIR_W-1:0] {
    DIR_UP, DIR_UP_RIGHT, DIR_RIGHT, DIR_DOWN_RIGHT,
    DIR_DOWN, DIR_DOWN_LEFT, DIR_LEFT, DIR_UP_LEFT
  } dir_e;
  typedef enum logic [TRIG_W-1:0] {
    TRIG_NONE, TRIG_DISPLAY_BOX, TRIG_SCREEN
  } trig_e;
  typedef struct packed {
    logic [DIR_W-1:0]   direction;
    logic [POS_W-1:0]   pos_x;
    logic [POS_W-1:0]   pos_y;
    logic [SPEED_W-1:0] speed;
    logic [TIME_W-1:0]  destroy_time;
    logic [TRIG_W-1:0]  destroy_trigger;
    logic [SIZE_W-1:0]  w;
    logic [SIZE_W-1:0]  h;
  } obj_params_t;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/object_spawn_dispatcher_if.sv
// object_spawn_dispatcher_if: spawn request channel plus the per-slot load/ack bus
// slave  = dispatcher view: takes spawn_* and slot_free/slot_update, drives spawn_ready, obj_* and strobes
// master = sequencer/slot-bank view, the mirror image
interface object_spawn_dispatcher_if
  import object_spawn_dispatcher_pkg::*;
#(
  parameter int N_SLOTS = 8
);
  logic                spawn_valid;
  logic                spawn_ready;
  logic [DIR_W-1:0]    spawn_direction;
  logic [POS_W-1:0]    spawn_pos_x;
  logic [POS_W-1:0]    spawn_pos_y;
  logic [SPEED_W-1:0]  spawn_speed;
  logic [TIME_W-1:0]   spawn_destroy_time;
  logic [TRIG_W-1:0]   spawn_destroy_trigger;
  logic [SIZE_W-1:0]   spawn_w;
  logic [SIZE_W-1:0]   spawn_h;
  logic [N_SLOTS-1:0]  slot_free;
  logic [N_SLOTS-1:0]  slot_update;
  logic [N_SLOTS-1:0]  sync_object_position_n;
  logic [DIR_W-1:0]    obj_direction;
  logic [POS_W-1:0]    obj_pos_x;
  logic [POS_W-1:0]    obj_pos_y;
  logic [SPEED_W-1:0]  obj_speed;
  logic [TIME_W-1:0]   obj_destroy_time;
  logic [TRIG_W-1:0]   obj_destroy_trigger;
  logic [SIZE_W-1:0]   obj_w;
  logic [SIZE_W-1:0]   obj_h;
  modport slave (
    input  spawn_valid, spawn_direction, spawn_pos_x, spawn_pos_y, spawn_speed,
           spawn_destroy_time, spawn_destroy_trigger, spawn_w, spawn_h,
           slot_free, slot_update,
    output spawn_ready, sync_object_position_n,
           obj_direction, obj_pos_x, obj_pos_y, obj_speed,
           obj_destroy_time, obj_destroy_trigger, obj_w, obj_h
  );
  modport master (
    output spawn_valid, spawn_direction, spawn_pos_x, spawn_pos_y, spawn_speed,
           spawn_destroy_time, spawn_destroy_trigger, spawn_w, spawn_h,
           slot_free, slot_update,
    input  spawn_ready, sync_object_position_n,
           obj_direction, obj_pos_x, obj_pos_y, obj_speed,
           obj_destroy_time, obj_destroy_trigger, obj_w, obj_h
  );
endinterface

// File: rtl/object_spawn_dispatcher_free_slot_picker.sv
// free_slot_picker: lowest-set-bit priority encoder over the available-slot mask
// i_avail: available slots; o_index: lowest available index; o_any: at least one available
module free_slot_picker #(
  parameter int N_SLOTS = 8
) (
  input  logic [N_SLOTS-1:0] i_avail,
  output logic [3:0]         o_index,
  output logic               o_any
);
  always_comb begin
    o_index = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) o_index = i_avail[k] ? 4'(k) : o_index;
  end
  assign o_any = |i_avail;
endmodule

// File: rtl/object_spawn_dispatcher.sv
// object_spawn_dispatcher: accepts spawn requests, loads the lowest free object slot via its active-low strobe
// i_clk_calculation/i_reset: clock and async active-high reset; bus: spawn channel and slot load bus (slave)
// o_active_slot: slot being loaded; o_busy: not idle; o_drop_count: saturating drops/aborts; o_load_error: timeout pulse
module object_spawn_dispatcher
  import object_spawn_dispatcher_pkg::*;
#(
  parameter int N_SLOTS = 8,
  parameter int ACK_TIMEOUT = 15,
  parameter int DROP_WHEN_FULL = 1
) (
  input  logic                       i_clk_calculation,
  input  logic                       i_reset,
  object_spawn_dispatcher_if.slave   bus,
  output logic [3:0]                 o_active_slot,
  output logic                       o_busy,
  output logic [7:0]                 o_drop_count,
  output logic                       o_load_error
);
  logic [2:0]         r_state, w_next;
  obj_params_t        r_obj;
  logic [N_SLOTS-1:0] r_reserved, r_strobe_n, w_avail, w_pick_mask, w_act_mask;
  logic [3:0]         r_active, w_pick;
  logic [7:0]         r_cnt, r_drops;
  logic               r_err, w_any, w_accept, w_sel_ok, w_drop, w_ack, w_timeout;
  // reserved masks slots already handed out whose free flag has not dropped yet
  assign w_avail = bus.slot_free & ~r_reserved;
  free_slot_picker #(.N_SLOTS(N_SLOTS)) u_picker (
    .i_avail (w_avail),
    .o_index (w_pick),
    .o_any   (w_any)
  );
  assign w_pick_mask = N_SLOTS'(1) << w_pick;
  assign w_act_mask = N_SLOTS'(1) << r_active;
  assign w_accept = bus.spawn_valid && r_state == ST_IDLE;
  assign w_sel_ok = r_state == ST_SELECT && w_any;
  assign w_drop = r_state == ST_SELECT && !w_any && DROP_WHEN_FULL != 0;
  assign w_ack = r_state == ST_WAIT_ACK && |(bus.slot_update & w_act_mask);
  // r_cnt counts strobe-low cycles including LOAD, so the strobe is low ACK_TIMEOUT+1 cycles; ack wins a tie
  assign w_timeout = r_state == ST_WAIT_ACK && !w_ack && r_cnt == 8'(ACK_TIMEOUT);
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:     w_next = w_accept ? ST_SELECT : ST_IDLE;
      ST_SELECT:   w_next = w_any ? ST_LOAD : (DROP_WHEN_FULL != 0) ? ST_IDLE : ST_SELECT;
      ST_LOAD:     w_next = ST_WAIT_ACK;
      ST_WAIT_ACK: w_next = (w_ack || w_timeout) ? ST_RELEASE : ST_WAIT_ACK;
      default:     w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk_calculation or posedge i_reset)
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_obj <= '0;
      r_reserved <= '0;
      r_strobe_n <= '1;
      r_active <= '0;
      r_cnt <= '0;
      r_drops <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_obj <= w_accept ? {bus.spawn_direction, bus.spawn_pos_x, bus.spawn_pos_y, bus.spawn_speed,
                           bus.spawn_destroy_time, bus.spawn_destroy_trigger, bus.spawn_w, bus.spawn_h} : r_obj;
      r_reserved <= (r_reserved & bus.slot_free & ~(w_timeout ? w_act_mask : '0)) | (w_sel_ok ? w_pick_mask : '0);
      r_strobe_n <= w_sel_ok ? ~w_pick_mask : (w_ack || w_timeout) ? '1 : r_strobe_n;
      r_active <= w_sel_ok ? w_pick : r_active;
      r_cnt <= r_state == ST_LOAD ? 8'd1 : r_state == ST_WAIT_ACK ? r_cnt + 8'd1 : r_cnt;
      r_drops <= (w_drop || w_timeout) ? sat_inc(r_drops) : r_drops;
      r_err <= w_timeout;
    end
  assign bus.spawn_ready = r_state == ST_IDLE;
  assign bus.sync_object_position_n = r_strobe_n;
  assign bus.obj_direction = r_obj.direction;
  assign bus.obj_pos_x = r_obj.pos_x;
  assign bus.obj_pos_y = r_obj.pos_y;
  assign bus.obj_speed = r_obj.speed;
  assign bus.obj_destroy_time = r_obj.destroy_time;
  assign bus.obj_destroy_trigger = r_obj.destroy_trigger;
  assign bus.obj_w = r_obj.w;
  assign bus.obj_h = r_obj.h;
  assign o_active_slot = r_active;
  assign o_busy = r_state != ST_IDLE;
  assign o_drop_count = r_drops;
  assign o_load_error = r_err;
endmodule

// File: tb/tb_object_spawn_dispatcher.sv
// tb_object_spawn_dispatcher: directed self-checking bench for the spawn dispatcher (drop and stall variants)
module tb_object_spawn_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [3:0] act, act2;
  logic busy, busy2, err, err2;
  logic [7:0] drops, drops2;
  object_spawn_dispatcher_if #(.N_SLOTS(8)) bus ();
  object_spawn_dispatcher_if #(.N_SLOTS(8)) bus2 ();
  object_spawn_dispatcher #(.N_SLOTS(8), .ACK_TIMEOUT(15), .DROP_WHEN_FULL(1)) u_dut (
    .i_clk_calculation (clk), .i_reset (rst), .bus (bus),
    .o_active_slot (act), .o_busy (busy), .o_drop_count (drops), .o_load_error (err)
  );
  object_spawn_dispatcher #(.N_SLOTS(8), .ACK_TIMEOUT(15), .DROP_WHEN_FULL(0)) u_dut_stall (
    .i_clk_calculation (clk), .i_reset (rst), .bus (bus2),
    .o_active_slot (act2), .o_busy (busy2), .o_drop_count (drops2), .o_load_error (err2)
  );
  always #5 clk = ~clk;
  // presents one request at a negedge, lets it be accepted, returns at the cycle-1 negedge with valid dropped
  task automatic start_spawn(input logic [9:0] x, input logic [9:0] y, input logic [4:0] spd);
    @(negedge clk);
    bus.spawn_valid = 1'b1;
    bus.spawn_pos_x = x;
    bus.spawn_pos_y = y;
    bus.spawn_speed = spd;
    bus.spawn_direction = 3'd3;
    bus.spawn_destroy_time = 8'd10;
    bus.spawn_destroy_trigger = 2'd1;
    bus.spawn_w = 10'd16;
    bus.spawn_h = 10'd24;
    @(posedge clk);
    @(negedge clk);
    bus.spawn_valid = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.spawn_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.spawn_ready); end
    checks++; if (bus.sync_object_position_n !== 8'hFF) begin failures++; $display("FAIL reset_strobe got=%h exp=ff", bus.sync_object_position_n); end
    checks++; if (bus.obj_pos_x !== 10'd0 || bus.obj_h !== 10'd0 || act !== 4'd0) begin failures++; $display("FAIL reset_obj got x=%0d h=%0d act=%0d exp=0", bus.obj_pos_x, bus.obj_h, act); end
    checks++; if (busy !== 1'b0 || drops !== 8'd0 || err !== 1'b0) begin failures++; $display("FAIL reset_status got busy=%0b drops=%0d err=%0b exp=0", busy, drops, err); end
    checks++; if (u_dut.r_reserved !== 8'h00) begin failures++; $display("FAIL reset_reserved got=%h exp=00", u_dut.r_reserved); end
    rst = 1'b0;
  endtask
  task automatic test_basic_spawn();
    start_spawn(10'd100, 10'd200, 5'd8);
    checks++; if (busy !== 1'b1 || bus.spawn_ready !== 1'b0 || bus.sync_object_position_n !== 8'hFF) begin failures++; $display("FAIL basic_select got busy=%0b rdy=%0b strobe=%h exp 1 0 ff", busy, bus.spawn_ready, bus.sync_object_position_n); end
    checks++; if (bus.obj_pos_x !== 10'd100 || bus.obj_pos_y !== 10'd200 || bus.obj_speed !== 5'd8 || bus.obj_direction !== 3'd3) begin failures++; $display("FAIL basic_obj got x=%0d y=%0d spd=%0d dir=%0d exp 100 200 8 3", bus.obj_pos_x, bus.obj_pos_y, bus.obj_speed, bus.obj_direction); end
    @(negedge clk);
    bus.spawn_pos_x = 10'd999;
    checks++; if (bus.sync_object_position_n !== 8'hFE || act !== 4'd0) begin failures++; $display("FAIL basic_load got strobe=%h act=%0d exp fe 0", bus.sync_object_position_n, act); end
    @(negedge clk);
    checks++; if (bus.sync_object_position_n !== 8'hFE) begin failures++; $display("FAIL basic_wait got strobe=%h exp fe", bus.sync_object_position_n); end
    bus.slot_update = 8'h01;
    @(negedge clk);
    bus.slot_update = 8'h00;
    checks++; if (bus.sync_object_position_n !== 8'hFF || busy !== 1'b1 || bus.spawn_ready !== 1'b0) begin failures++; $display("FAIL basic_release got strobe=%h busy=%0b rdy=%0b exp ff 1 0", bus.sync_object_position_n, busy, bus.spawn_ready); end
    checks++; if (bus.obj_pos_x !== 10'd100) begin failures++; $display("FAIL basic_obj_stable got x=%0d exp 100", bus.obj_pos_x); end
    @(negedge clk);
    checks++; if (bus.spawn_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || drops !== 8'd0) begin failures++; $display("FAIL basic_idle got rdy=%0b busy=%0b err=%0b drops=%0d exp 1 0 0 0", bus.spawn_ready, busy, err, drops); end
    checks++; if (u_dut.r_reserved !== 8'h01) begin failures++; $display("FAIL basic_reserved got=%h exp=01", u_dut.r_reserved); end
  endtask
  task automatic test_second_pick();
    bus.slot_free = 8'hF1;
    start_spawn(10'd300, 10'd40, 5'd2);
    @(negedge clk);
    checks++; if (bus.sync_object_position_n !== 8'hEF || act !== 4'd4) begin failures++; $display("FAIL pick4_load got strobe=%h act=%0d exp ef 4", bus.sync_object_position_n, act); end
    @(negedge clk);
    bus.slot_update = 8'h01;
    @(negedge clk);
    checks++; if (bus.sync_object_position_n !== 8'hEF || busy !== 1'b1) begin failures++; $display("FAIL pick4_foreign_ack got strobe=%h busy=%0b exp ef 1", bus.sync_object_position_n, busy); end
    bus.slot_update = 8'h10;
    @(negedge clk);
    bus.slot_update = 8'h00;
    checks++; if (bus.sync_object_position_n !== 8'hFF || bus.obj_pos_x !== 10'd300) begin failures++; $display("FAIL pick4_release got strobe=%h x=%0d exp ff 300", bus.sync_object_position_n, bus.obj_pos_x); end
    @(negedge clk);
    checks++; if (bus.spawn_ready !== 1'b1 || u_dut.r_reserved !== 8'h11) begin failures++; $display("FAIL pick4_idle got rdy=%0b rsv=%h exp 1 11", bus.spawn_ready, u_dut.r_reserved); end
  endtask
  task automatic test_drop_full();
    bus.slot_free = 8'h00;
    start_spawn(10'd7, 10'd7, 5'd1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_select got busy=%0b exp 1", busy); end
    @(negedge clk);
    checks++; if (bus.spawn_ready !== 1'b1 || drops !== 8'd1 || bus.sync_object_position_n !== 8'hFF) begin failures++; $display("FAIL drop_count got rdy=%0b drops=%0d strobe=%h exp 1 1 ff", bus.spawn_ready, drops, bus.sync_object_position_n); end
    checks++; if (u_dut.r_reserved !== 8'h00 || err !== 1'b0) begin failures++; $display("FAIL drop_reserved got rsv=%h err=%0b exp 00 0", u_dut.r_reserved, err); end
  endtask
  task automatic test_timeout();
    int low = 0, errs = 0, err_cyc = -1, last_low = -1;
    bus.slot_free = 8'hFF;
    start_spawn(10'd50, 10'd60, 5'd4);
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      if (bus.sync_object_position_n !== 8'hFF) begin low++; last_low = c; end
      if (err === 1'b1) begin errs++; err_cyc = c; end
    end
    checks++; if (low !== 16 || last_low !== 17) begin failures++; $display("FAIL timeout_low got low=%0d last=%0d exp 16 17", low, last_low); end
    checks++; if (errs !== 1 || err_cyc !== 18) begin failures++; $display("FAIL timeout_err got pulses=%0d cyc=%0d exp 1 18", errs, err_cyc); end
    checks++; if (drops !== 8'd2 || u_dut.r_reserved !== 8'h00) begin failures++; $display("FAIL timeout_count got drops=%0d rsv=%h exp 2 00", drops, u_dut.r_reserved); end
    start_spawn(10'd51, 10'd61, 5'd4);
    @(negedge clk);
    checks++; if (bus.sync_object_position_n !== 8'hFE || act !== 4'd0) begin failures++; $display("FAIL timeout_reuse got strobe=%h act=%0d exp fe 0", bus.sync_object_position_n, act); end
    @(negedge clk);
    bus.slot_update = 8'h01;
    @(negedge clk);
    bus.slot_update = 8'h00;
    @(negedge clk);
    checks++; if (bus.spawn_ready !== 1'b1 || drops !== 8'd2) begin failures++; $display("FAIL timeout_reuse_done got rdy=%0b drops=%0d exp 1 2", bus.spawn_ready, drops); end
  endtask
  task automatic test_ack_at_timeout();
    int low = 0, errs = 0;
    start_spawn(10'd5, 10'd6, 5'd3);
    for (int c = 2; c <= 22; c++) begin
      @(negedge clk);
      if (bus.sync_object_position_n !== 8'hFF) low++;
      if (err === 1'b1) errs++;
      bus.slot_update = (c == 17) ? 8'h02 : 8'h00;
    end
    checks++; if (low !== 16 || errs !== 0) begin failures++; $display("FAIL ack_tie got low=%0d errs=%0d exp 16 0", low, errs); end
    checks++; if (drops !== 8'd2 || act !== 4'd1 || bus.spawn_ready !== 1'b1) begin failures++; $display("FAIL ack_tie_state got drops=%0d act=%0d rdy=%0b exp 2 1 1", drops, act, bus.spawn_ready); end
  endtask
  task automatic test_stall();
    int bad = 0;
    @(negedge clk);
    bus2.slot_free = 8'h00;
    bus2.spawn_valid = 1'b1;
    bus2.spawn_pos_x = 10'd77;
    @(posedge clk);
    @(negedge clk);
    bus2.spawn_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus2.spawn_ready !== 1'b0 || bus2.sync_object_position_n !== 8'hFF || drops2 !== 8'd0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL stall_hold got bad_cycles=%0d exp 0", bad); end
    bus2.slot_free = 8'h04;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus2.sync_object_position_n !== 8'hFB || act2 !== 4'd2 || bus2.obj_pos_x !== 10'd77) begin failures++; $display("FAIL stall_load got strobe=%h act=%0d x=%0d exp fb 2 77", bus2.sync_object_position_n, act2, bus2.obj_pos_x); end
    bus2.slot_update = 8'h04;
    @(negedge clk);
    bus2.slot_update = 8'h00;
    @(negedge clk);
    checks++; if (bus2.spawn_ready !== 1'b1 || drops2 !== 8'd0) begin failures++; $display("FAIL stall_done got rdy=%0b drops=%0d exp 1 0", bus2.spawn_ready, drops2); end
  endtask
  task automatic test_reset_mid();
    start_spawn(10'd9, 10'd9, 5'd9);
    repeat (3) @(negedge clk);
    checks++; if (bus.sync_object_position_n === 8'hFF || busy !== 1'b1) begin failures++; $display("FAIL midrst_pre got strobe=%h busy=%0b exp low 1", bus.sync_object_position_n, busy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.sync_object_position_n !== 8'hFF || busy !== 1'b0) begin failures++; $display("FAIL midrst_async got strobe=%h busy=%0b exp ff 0", bus.sync_object_position_n, busy); end
    checks++; if (drops !== 8'd0 || err !== 1'b0) begin failures++; $display("FAIL midrst_count got drops=%0d err=%0b exp 0 0", drops, err); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_saturation();
    bus.slot_free = 8'h00;
    @(negedge clk);
    bus.spawn_valid = 1'b1;
    repeat (508) @(negedge clk);
    checks++; if (drops !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp 254", drops); end
    repeat (92) @(negedge clk);
    bus.spawn_valid = 1'b0;
    checks++; if (drops !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp 255", drops); end
    repeat (4) @(negedge clk);
    checks++; if (drops !== 8'd255 || bus.sync_object_position_n !== 8'hFF) begin failures++; $display("FAIL sat_hold got drops=%0d strobe=%h exp 255 ff", drops, bus.sync_object_position_n); end
  endtask
  initial begin
    bus.spawn_valid = 1'b0;
    bus.spawn_direction = '0;
    bus.spawn_pos_x = '0;
    bus.spawn_pos_y = '0;
    bus.spawn_speed = '0;
    bus.spawn_destroy_time = '0;
    bus.spawn_destroy_trigger = '0;
    bus.spawn_w = '0;
    bus.spawn_h = '0;
    bus.slot_free = 8'hFF;
    bus.slot_update = 8'h00;
    bus2.spawn_valid = 1'b0;
    bus2.spawn_direction = '0;
    bus2.spawn_pos_x = '0;
    bus2.spawn_pos_y = '0;
    bus2.spawn_speed = '0;
    bus2.spawn_destroy_time = '0;
    bus2.spawn_destroy_trigger = '0;
    bus2.spawn_w = '0;
    bus2.spawn_h = '0;
    bus2.slot_free = 8'hFF;
    bus2.slot_update = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_spawn();
    test_second_pick();
    test_drop_full();
    test_timeout();
    test_ack_at_timeout();
    test_stall();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
